// File: rtl/interboard_msg_queue.sv
// interboard_msg_queue: FIFO of game-control messages that feeds the interboard sender.
// Entries leave the queue one at a time as a one-cycle o_ctrl_en plus held o_ctrl_* fields.
// An entry is issued only when the sender is idle (i_send_ready) and this board holds the
// transmit turn (i_transmit).
// Optional feature macro: MSGQ_COALESCE_EN. When it is defined, a cursor-move push overwrites
// a queued cursor-move tail entry in place instead of taking a new slot.
module interboard_msg_queue #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned BUSY_TIMEOUT = 15,
    parameter logic [3:0]  MOVE_TYPE    = 4'd1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_interboard_rst,
    input  logic                   i_transmit,
    input  logic                   i_push_en,
    input  logic                   i_push_move_dir,
    input  logic [4:0]             i_push_block_x,
    input  logic [2:0]             i_push_block_y,
    input  logic [3:0]             i_push_msg_type,
    input  logic [5:0]             i_push_card,
    input  logic [2:0]             i_push_sel_len,
    input  logic                   i_send_ready,
    output logic                   o_ctrl_en,
    output logic                   o_ctrl_move_dir,
    output logic [4:0]             o_ctrl_block_x,
    output logic [2:0]             o_ctrl_block_y,
    output logic [3:0]             o_ctrl_msg_type,
    output logic [5:0]             o_ctrl_card,
    output logic [2:0]             o_ctrl_sel_len,
    output logic                   o_q_full,
    output logic                   o_q_empty,
    output logic [$clog2(DEPTH):0] o_q_count,
    output logic                   o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

    // Entry layout: {move_dir, block_x, block_y, msg_type, card, sel_len}; msg_type is [12:9].
    localparam int unsigned EW = 22;

    typedef enum logic [1:0] {
        StIdle,
        StWaitBusy,
        StWaitReady
    } t_state;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    t_state        r_state;
    logic [TW-1:0] r_tcnt;
    logic          r_ctrl_en;
    logic [EW-1:0] r_ctrl;

    logic          w_rst;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_coalesce;
    logic          w_advance;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_ptr;
    logic [EW-1:0] w_push_entry;

    assign w_rst   = i_rst | i_interboard_rst;
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    assign w_push_entry = {i_push_move_dir, i_push_block_x, i_push_block_y,
                           i_push_msg_type, i_push_card, i_push_sel_len};

    // Only the idle state may take the head; the sender handshake gates the rest.
    assign w_pop = (r_state == StIdle) && !w_empty && i_send_ready && i_transmit;

`ifdef MSGQ_COALESCE_EN
    logic [AW-1:0] w_tail_ptr;
    assign w_tail_ptr = r_wptr - 1'b1;
    // When the tail is also the head being popped this cycle, it is already in flight,
    // so the push must take a fresh slot instead.
    assign w_coalesce = i_push_en && (i_push_msg_type == MOVE_TYPE) && !w_empty
                        && (r_mem[w_tail_ptr][12:9] == MOVE_TYPE)
                        && !(w_pop && (r_count == CW'(1)));
    assign w_wr_ptr   = w_coalesce ? w_tail_ptr : r_wptr;
`else
    assign w_coalesce = 1'b0;
    assign w_wr_ptr   = r_wptr;
`endif

    // Fullness uses the registered count, so a push in the same cycle as a pop is still dropped.
    assign w_advance = i_push_en && !w_full && !w_coalesce;
    assign w_wr_en   = w_advance || w_coalesce;

    // Entry storage; stale contents are harmless because the count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_ptr] <= w_push_entry;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_advance) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_advance, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_push_en && w_full && !w_coalesce) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Issue FSM: pop into the ctrl registers, then follow the sender's busy/ready handshake.
    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_state   <= StIdle;
            r_tcnt    <= '0;
            r_ctrl_en <= 1'b0;
            r_ctrl    <= '0;
        end else begin
            r_ctrl_en <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_ctrl    <= r_mem[r_rptr];
                        r_ctrl_en <= 1'b1;
                        r_tcnt    <= '0;
                        r_state   <= StWaitBusy;
                    end
                end
                StWaitBusy: begin
                    if (!i_send_ready) begin
                        r_tcnt  <= '0;
                        r_state <= StWaitReady;
                    end else if (r_tcnt == TW'(BUSY_TIMEOUT - 1)) begin
                        // Sender never reported busy; treat the issue as accepted.
                        r_tcnt  <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                StWaitReady: begin
                    if (i_send_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_ctrl_en       = r_ctrl_en;
    assign o_ctrl_move_dir = r_ctrl[21];
    assign o_ctrl_block_x  = r_ctrl[20:16];
    assign o_ctrl_block_y  = r_ctrl[15:13];
    assign o_ctrl_msg_type = r_ctrl[12:9];
    assign o_ctrl_card     = r_ctrl[8:3];
    assign o_ctrl_sel_len  = r_ctrl[2:0];
    assign o_q_full        = w_full;
    assign o_q_empty       = w_empty;
    assign o_q_count       = r_count;
    assign o_overflow      = r_overflow;

endmodule

// File: doc/interboard_msg_queue.md
Name: interboard_msg_queue

Overview:
Upstream feeder for the interboard communication top. Buffers game-control messages (move_dir, block_x, block_y, msg_type, card, sel_len) in a FIFO. Issues them one at a time as a one-cycle ctrl_en plus held ctrl_* fields, and only when the sender reports send_ready and this board holds the transmit turn. This prevents messages being lost while a previous message is still being serialised.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..32.
BUSY_TIMEOUT, 15, cycles to wait in WAIT_BUSY for send_ready to fall before treating the issue as accepted.
MOVE_TYPE, 4'd1, msg_type code for a cursor-move message (used only by the optional feature).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
interboard_rst  in  1  reset from the other board; same effect as rst
transmit  in  1  this board's turn; dequeue only while high
push_en  in  1  one-pulse request to enqueue the push_* fields
push_move_dir  in  1  message field
push_block_x  in  5  message field
push_block_y  in  3  message field
push_msg_type  in  4  message field
push_card  in  6  message field
push_sel_len  in  3  message field
send_ready  in  1  sender idle and able to accept
ctrl_en  out  1  one-pulse issue strobe to the sender
ctrl_move_dir, ctrl_block_x, ctrl_block_y, ctrl_msg_type, ctrl_card, ctrl_sel_len  out  1/5/3/4/6/3  registered fields of the issued entry
q_full  out  1  count == DEPTH
q_empty  out  1  count == 0
q_count  out  $clog2(DEPTH)+1  occupancy
overflow  out  1  sticky; set when a push is dropped

Behaviour:
- Reset (rst or interboard_rst, sampled at posedge):
  - count = 0, read/write pointers = 0, state = IDLE, timeout counter = 0.
  - ctrl_en = 0, all ctrl_* = 0, overflow = 0.
  - q_empty = 1, q_full = 0.
- Storage: 22-bit entries in a circular buffer. Pointers wrap modulo DEPTH.
- Push:
  - On push_en with count < DEPTH, write at wptr; count is visible +1 the next cycle.
  - On push_en while full, the push is dropped and overflow is set to 1 until reset.
- Simultaneous push and pop in one cycle: count is unchanged; both pointers advance.
  - When full, a push in the same cycle as a pop is still dropped, because full is evaluated on the registered count.
- FSM states:
  - IDLE: when !q_empty && send_ready && transmit, pop the head into the ctrl_* registers, set ctrl_en = 1 for exactly one cycle, and go to WAIT_BUSY.
  - WAIT_BUSY: wait for send_ready == 0, then go to WAIT_READY. If BUSY_TIMEOUT cycles elapse with send_ready still 1, go to IDLE.
  - WAIT_READY: wait for send_ready == 1, then go to IDLE.
- Latency: a push accepted at edge E0 into an empty queue, with send_ready = 1 and transmit = 1, gives ctrl_en high for the cycle following edge E1. The minimum spacing between two ctrl_en pulses is 3 cycles.
- ctrl_* hold their last issued value between issues; only a pop updates them.
- transmit dropping mid-transaction does not abort WAIT_BUSY or WAIT_READY; it only blocks new issues from IDLE.
- Queued entries survive a transmit change; only a reset flushes the queue.
- A reset mid-transaction aborts immediately. ctrl_en is never high in the cycle after reset is asserted.

Optional Feature:
MSGQ_COALESCE_EN:
- Defined: a push with push_msg_type == MOVE_TYPE, arriving when the queue is non-empty and the tail entry (wptr-1) also has msg_type == MOVE_TYPE, overwrites the tail entry in place.
  - count is unchanged and overflow is not set, even when full.
  - The popped entry has already left the FIFO, so an in-flight message is never modified.
  - If the same cycle also pops and the tail is the head (count == 1), no coalescing occurs; a normal push is performed.
- Undefined: every push is enqueued normally.

Test Plan:
- Reset, then push one entry (block_x=5'd7, card=6'd12) with transmit=1, send_ready=1 -> ctrl_en for exactly one cycle, 2 edges after the push; ctrl_block_x=7, ctrl_card=12; q_empty=1 afterwards.
- send_ready held 0, 9 pushes with DEPTH=8 -> q_full=1, q_count=8, overflow=1; the 9th message is never issued; the 8 messages drain in order once send_ready toggles.
- transmit=0 with 3 entries queued -> no ctrl_en; raise transmit -> 3 issues; each waits for send_ready to fall then rise, and none is closer than 3 cycles to the previous one.
- send_ready stuck at 1 after an issue -> next ctrl_en exactly BUSY_TIMEOUT+1 cycles after the previous one.
- interboard_rst pulse mid-WAIT_BUSY with 4 entries queued -> next cycle q_count=0, ctrl_* = 0, state IDLE, overflow cleared.
- MSGQ_COALESCE_EN defined, with send_ready=0: push MOVE(x=1), MOVE(x=2), then type 4'd3 -> q_count=2; the entries issue as x=2 then the type-3 entry. Without the macro -> q_count=3.
